// File: rtl/fk_history_seq.sv
// Sample-history capture and tap-select sequencer for the shared filter MAC.
// Optional build macro FK_FLUSH_EN adds a `flush` input that zeroes the history while idle.
module fk_history_seq #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             clear_overrun,
`ifdef FK_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] fk,
  output logic [WIDTH-1:0] fk_1,
  output logic [WIDTH-1:0] fk_2,
  output logic [1:0]       select,
  output logic             step_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  // Handshake: sample_valid is a one-cycle qualifier with no ready; it is
  // accepted only when idle (busy=0), otherwise the sample is dropped and
  // the sticky overrun flag records the loss.

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_tap0 = 3'd1,
    st_tap1 = 3'd2,
    st_tap2 = 3'd3,
    st_done = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   flush_req;
  logic   capture;
  logic   drop;

`ifdef FK_FLUSH_EN
  assign flush_req = flush & (state == st_idle);
`else
  assign flush_req = 1'b0;
`endif

  // Flush beats a same-cycle sample: the sample is discarded, not counted as a drop.
  assign capture = (state == st_idle) & sample_valid & ~flush_req;
  assign drop    = (state != st_idle) & sample_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nxt;
  end

  // Outputs decode from state only, so no input reaches an output combinationally.
  always_comb begin
    state_nxt  = state;
    select     = 2'b11;
    step_valid = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      st_idle: begin
        busy = 1'b0;
        if (capture) state_nxt = st_tap0;
      end
      st_tap0: begin
        select     = 2'b00;
        step_valid = 1'b1;
        state_nxt  = st_tap1;
      end
      st_tap1: begin
        select     = 2'b01;
        step_valid = 1'b1;
        state_nxt  = st_tap2;
      end
      st_tap2: begin
        select     = 2'b10;
        step_valid = 1'b1;
        state_nxt  = st_done;
      end
      st_done: begin
        frame_done = 1'b1;
        state_nxt  = st_idle;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fk   <= '0;
      fk_1 <= '0;
      fk_2 <= '0;
    end else if (flush_req) begin
      fk   <= '0;
      fk_1 <= '0;
      fk_2 <= '0;
    end else if (capture) begin
      fk_2 <= fk_1;
      fk_1 <= fk;
      fk   <= sample_in;
    end
  end

  // A drop in the same cycle as a clear still leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             overrun <= 1'b0;
    else if (drop)          overrun <= 1'b1;
    else if (clear_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_fk_history_seq.sv
// Self-checking bench for fk_history_seq: directed scenarios plus a randomized run
// against a phase-counter reference model of the frame sequence.
module tb_fk_history_seq;
  localparam int W = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         clear_overrun = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] fk, fk_1, fk_2;
  logic [1:0]   select;
  logic         step_valid, frame_done, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;

  fk_history_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear_overrun(clear_overrun),
`ifdef FK_FLUSH_EN
    .flush(flush),
`endif
    .fk(fk), .fk_1(fk_1), .fk_2(fk_2), .select(select), .step_valid(step_valid),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1..3 = taps 0..2, 4 = frame-done cycle.
  int           m_phase = 0;
  logic [W-1:0] m_hist[3] = '{default: '0};
  logic         m_ovr = 1'b0;

  function automatic logic [1:0] exp_select();
    return (m_phase >= 1 && m_phase <= 3) ? 2'(m_phase - 1) : 2'b11;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_hist  = '{default: '0};
    m_ovr   = 1'b0;
  endtask

  task automatic model_edge();
    int old_phase = m_phase;
    if (old_phase == 0) begin
      if (flush) m_hist = '{default: '0};
      else if (sample_valid) begin
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = sample_in;
        m_phase = 1;
      end
    end else begin
      m_phase = (old_phase == 4) ? 0 : old_phase + 1;
    end
    if (old_phase != 0 && sample_valid) m_ovr = 1'b1;
    else if (clear_overrun) m_ovr = 1'b0;
  endtask

  // One active edge; the model tracks the DUT, outputs are then sampled 1ns later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    sample_valid = 1'b0;
    clear_overrun = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    n_cmp++; if (select !== 2'b11) begin n_err++; $display("FAIL reset_select got=%b exp=11", select); end
    n_cmp++; if ({step_valid, frame_done, busy, overrun} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {step_valid, frame_done, busy, overrun}); end
    n_cmp++; if ({fk, fk_1, fk_2} !== '0) begin n_err++; $display("FAIL reset_hist got=%h/%h/%h exp=0/0/0", fk, fk_1, fk_2); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_frames();
    logic [1:0] sel_exp[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] sv_exp = 4'b0111;
    for (int s = 1; s <= 3; s++) begin
      sample_in = W'(s);
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (select !== sel_exp[k]) begin n_err++; $display("FAIL basic_select s=%0d k=%0d got=%b exp=%b", s, k, select, sel_exp[k]); end
        n_cmp++; if (step_valid !== sv_exp[k]) begin n_err++; $display("FAIL basic_step_valid s=%0d k=%0d got=%b exp=%b", s, k, step_valid, sv_exp[k]); end
        n_cmp++; if (frame_done !== (k == 3)) begin n_err++; $display("FAIL basic_frame_done s=%0d k=%0d got=%b", s, k, frame_done); end
        step();
      end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle s=%0d busy=%b exp=0", s, busy); end
      step();
    end
    n_cmp++; if ({fk, fk_1, fk_2} !== {25'd3, 25'd2, 25'd1}) begin n_err++; $display("FAIL basic_hist got=%h/%h/%h exp=3/2/1", fk, fk_1, fk_2); end
  endtask

  task automatic test_back_to_back();
    sample_in = 25'h1FFFFFF; sample_valid = 1'b1;
    step();
    sample_in = 25'h0AAAAAA;
    step();
    sample_valid = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
    n_cmp++; if (fk !== 25'h1FFFFFF || fk_1 !== 25'd3) begin n_err++; $display("FAIL b2b_hist got=%h/%h exp=1ffffff/3", fk, fk_1); end
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0 || overrun !== 1'b1) begin n_err++; $display("FAIL b2b_after_frame busy=%b ovr=%b exp=0/1", busy, overrun); end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_drop_in_done();
    sample_in = 25'h0000123; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (3) step();
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL done_cycle frame_done=%b exp=1", frame_done); end
    sample_in = 25'h0000456; sample_valid = 1'b1;
    step();
    n_cmp++; if (overrun !== 1'b1 || fk !== 25'h0000123) begin n_err++; $display("FAIL done_drop ovr=%b fk=%h exp=1/123", overrun, fk); end
    sample_in = 25'h0000789;
    step();
    sample_valid = 1'b0;
    n_cmp++; if (fk !== 25'h0000789 || fk_1 !== 25'h0000123 || select !== 2'b00) begin n_err++; $display("FAIL n5_accept fk=%h fk_1=%h sel=%b exp=789/123/00", fk, fk_1, select); end
    repeat (4) step();
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
  endtask

  task automatic test_clear_vs_drop();
    sample_in = 25'h0000042; sample_valid = 1'b1;
    step();
    clear_overrun = 1'b1;
    step();
    sample_valid = 1'b0; clear_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL clear_vs_drop got=%b exp=1", overrun); end
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    sample_in = 25'h0ABCDEF; sample_valid = 1'b1;
    step();
    step();
    sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (select !== 2'b11 || busy !== 1'b0 || step_valid !== 1'b0) begin n_err++; $display("FAIL async_ctrl sel=%b busy=%b sv=%b exp=11/0/0", select, busy, step_valid); end
    n_cmp++; if ({fk, fk_1, fk_2} !== '0 || overrun !== 1'b0) begin n_err++; $display("FAIL async_state fk=%h ovr=%b exp=0/0", fk, overrun); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 1) rst_n = 1'b1;
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL async_no_done i=%0d got=%b exp=0", i, frame_done); end
    end
    sample_in = 25'h0000005; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    n_cmp++; if ({fk, fk_1, fk_2} !== {25'd5, 25'd0, 25'd0}) begin n_err++; $display("FAIL async_recapture got=%h/%h/%h exp=5/0/0", fk, fk_1, fk_2); end
    repeat (4) step();
  endtask

`ifdef FK_FLUSH_EN
  task automatic test_flush();
    for (int v = 5; v <= 7; v++) begin
      sample_in = W'(v); sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      repeat (4) step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if ({fk, fk_1, fk_2} !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_idle hist=%h/%h/%h busy=%b exp=0", fk, fk_1, fk_2, busy); end
    sample_in = 25'h9; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (fk !== 25'h9) begin n_err++; $display("FAIL flush_tap0 fk=%h exp=9", fk); end
    repeat (3) step();
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    sample_in = 25'h1234; sample_valid = 1'b1; flush = 1'b1;
    step();
    sample_valid = 1'b0; flush = 1'b0;
    n_cmp++; if ({fk, fk_1, fk_2} !== '0 || busy !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL flush_vs_sample fk=%h busy=%b ovr=%b exp=0/0/0", fk, busy, overrun); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      sample_valid  = ($urandom_range(0, 3) == 0);
      sample_in     = W'($urandom);
      clear_overrun = ($urandom_range(0, 7) == 0);
`ifdef FK_FLUSH_EN
      flush         = ($urandom_range(0, 15) == 0);
`endif
      step();
      n_cmp++; if (select !== exp_select()) begin n_err++; $display("FAIL rand_select i=%0d got=%b exp=%b", i, select, exp_select()); end
      n_cmp++; if ({step_valid, frame_done, busy} !== {m_phase >= 1 && m_phase <= 3, m_phase == 4, m_phase != 0}) begin n_err++; $display("FAIL rand_flags i=%0d got=%b phase=%0d", i, {step_valid, frame_done, busy}, m_phase); end
      n_cmp++; if ({fk, fk_1, fk_2} !== {m_hist[0], m_hist[1], m_hist[2]}) begin n_err++; $display("FAIL rand_hist i=%0d got=%h/%h/%h exp=%h/%h/%h", i, fk, fk_1, fk_2, m_hist[0], m_hist[1], m_hist[2]); end
      n_cmp++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rand_overrun i=%0d got=%b exp=%b", i, overrun, m_ovr); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_frames();
    test_back_to_back();
    test_drop_in_done();
    test_clear_vs_drop();
    test_async_reset();
`ifdef FK_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
